isp_dgain_ctrl: RTL
===================

// Module: isp_dgain_ctrl
// PURPOSE
//  Frame-synchronous digital-gain controller for the ISP DG stage. Consumes one AE
//  response per frame, steps a saturating gain-table index, and defers every change
//  to the next frame_start so gain never changes mid-frame. After each change it
//  blanks AE for a programmable number of frames to let exposure settle. Owns the
//  gain LUT (firmware-written) and drives dgain_value to the DG multiplier.
// PARAMETERS
//  DGAIN_ARRAY_SIZE  100                        number of gain LUT entries
//  DGAIN_ARRAY_BITS  $clog2(DGAIN_ARRAY_SIZE)   index width
//  GAIN_W            8                          gain word width (U4.4)
//  SETTLE_W          4                          settle-frame counter width
//  INIT_INDEX        0                          index after reset
//  UNITY_GAIN        8'h10                      dgain_value after reset
// PORTS
//  pclk            in   1                 clock
//  rst_n           in   1                 synchronous active-low reset
//  enable          in   1                 level; 0 forces IDLE
//  frame_start     in   1                 1-cycle pulse per frame (vsync edge)
//  ae_valid        in   1                 1-cycle pulse, qualifies ae_response
//  ae_response     in   2                 00 hold, 01 darker(-1), 10 hold, 11 brighter(+1)
//  manual_mode     in   1                 1: index from manual_index, AE ignored
//  manual_index    in   DGAIN_ARRAY_BITS  forced index (clamped to SIZE-1)
//  settle_frames   in   SETTLE_W          AE-blank frames after each change
//  cfg_we          in   1                 LUT write strobe
//  cfg_addr        in   DGAIN_ARRAY_BITS  LUT write address
//  cfg_wdata       in   GAIN_W            LUT write data
//  dgain_index     out  DGAIN_ARRAY_BITS  applied index
//  dgain_value     out  GAIN_W            applied gain = LUT[dgain_index]
//  dgain_update    out  1                 1-cycle pulse when index/value change
//  busy            out  1                 1 in PENDING, APPLY, SETTLE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE, dgain_index=INIT_INDEX,
//   dgain_value=UNITY_GAIN, dgain_update=0, busy=0, settle cnt=0. LUT not reset.
//  Next-index: 01 -> idx==0 ? 0 : idx-1; 11 -> idx==SIZE-1 ? idx : idx+1; 00/10 -> idx.
//  FSM states IDLE, WAIT_STATS, PENDING, APPLY, SETTLE:
//   IDLE: enable=1 -> WAIT_STATS.
//   WAIT_STATS: ae_valid & next!=dgain_index -> latch pend_idx, PENDING; else stay.
//   PENDING: frame_start -> APPLY (LUT read addr=pend_idx). ae_valid without
//    frame_start -> recompute from dgain_index, overwrite pend_idx (latest wins);
//    if result==dgain_index -> WAIT_STATS.
//   APPLY (1 cycle): at its end dgain_index<=pend_idx, dgain_value<=LUT data,
//    dgain_update=1 for the following cycle; settle_frames==0 -> WAIT_STATS, else
//    cnt<=settle_frames, SETTLE.
//   SETTLE: ae_valid discarded; each frame_start decrements cnt; cnt 1->0 -> WAIT_STATS.
//  Latency: frame_start to dgain_update = 2 cycles; index and value change together.
//  Manual: in WAIT_STATS/SETTLE, frame_start with clamp(manual_index)!=dgain_index
//   -> pend_idx=clamp, APPLY (settle applied). AE ignored while manual_mode=1.
//  Simultaneous: ae_valid+frame_start in WAIT_STATS -> PENDING, that frame_start
//   not consumed; in PENDING frame_start wins, ae_valid dropped.
//  enable=0 in any state -> IDLE next cycle; pend_idx discarded, dgain_index/value
//   held; an APPLY in progress is abandoned (no update pulse).
//  LUT: cfg_we writes at posedge; cfg_addr>=SIZE ignored; write to address read in
//   same cycle returns old data (read-before-write). Writing LUT[dgain_index] does
//   not change dgain_value until the next APPLY.
// STRUCTURE
//  Shared package isp_pkg: FSM state enum (3b), ae_response codes AE_HOLD/AE_DARK/
//  AE_RSVD/AE_BRIGHT. Sub-module isp_dgain_lut: SIZE x GAIN_W sync-read RAM, 1 wr port.
//  Next-index saturating step is a local function.
// TESTING
//  1 reset: idx=INIT_INDEX=0, value=8'h10, busy=0; hold enable=0, pulses -> no change.
//  2 LUT[5]=8'h20, idx=4, settle=0, ae 11 then frame_start -> update 2 cyc later,
//    idx=5, value=8'h20; ae 01 at idx 0 -> stays WAIT_STATS, no update.
//  3 idx=99, ae 11 -> no PENDING; ae 01,01 in PENDING -> pend=98, apply 98 only.
//  4 settle=2: apply, then ae_valid in next 2 frames ignored; 3rd frame ae acts.
//  5 ae_valid+frame_start same cycle -> apply on following frame_start; enable drop
//    in PENDING -> IDLE, no update, idx held.
//  6 manual_mode=1, manual_index=120 -> frame_start applies idx 99; AE ignored.

Source files
------------

// File: rtl/isp_pkg.sv
// Shared ISP definitions: digital-gain controller FSM states and AE response codes.
package isp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_STATS = 3'd1,
    ST_PENDING    = 3'd2,
    ST_APPLY      = 3'd3,
    ST_SETTLE     = 3'd4
  } dgain_state_e;

  localparam logic [1:0] AE_HOLD   = 2'b00;
  localparam logic [1:0] AE_DARK   = 2'b01;
  localparam logic [1:0] AE_RSVD   = 2'b10;
  localparam logic [1:0] AE_BRIGHT = 2'b11;

endpackage

// File: rtl/isp_dgain_lut.sv
// Gain lookup table: single write port, registered read, read-before-write on collision.
module isp_dgain_lut #(
  parameter int unsigned SIZE = 100,
  parameter int unsigned AW   = 7,
  parameter int unsigned GW   = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [GW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [GW-1:0] rdata
);

  logic [GW-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < SIZE)) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/isp_dgain_ctrl.sv
// Frame-synchronous digital-gain controller: steps a LUT index from AE responses and
// applies each change only at a frame boundary, then blanks AE for settle frames.
import isp_pkg::*;

module isp_dgain_ctrl #(
  parameter int unsigned DGAIN_ARRAY_SIZE = 100,
  parameter int unsigned DGAIN_ARRAY_BITS = $clog2(DGAIN_ARRAY_SIZE),
  parameter int unsigned GAIN_W           = 8,
  parameter int unsigned SETTLE_W         = 4,
  parameter int unsigned INIT_INDEX       = 0,
  parameter logic [GAIN_W-1:0] UNITY_GAIN = 8'h10
) (
  input  logic                        pclk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        frame_start,
  input  logic                        ae_valid,
  input  logic [1:0]                  ae_response,
  input  logic                        manual_mode,
  input  logic [DGAIN_ARRAY_BITS-1:0] manual_index,
  input  logic [SETTLE_W-1:0]         settle_frames,
  input  logic                        cfg_we,
  input  logic [DGAIN_ARRAY_BITS-1:0] cfg_addr,
  input  logic [GAIN_W-1:0]           cfg_wdata,
  output logic [DGAIN_ARRAY_BITS-1:0] dgain_index,
  output logic [GAIN_W-1:0]           dgain_value,
  output logic                        dgain_update,
  output logic                        busy
);

  localparam int unsigned IW = DGAIN_ARRAY_BITS;
  localparam logic [IW-1:0] MAX_IDX = IW'(DGAIN_ARRAY_SIZE - 1);

  dgain_state_e         state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        pend_q, pend_d;
  logic [GAIN_W-1:0]    val_q, val_d;
  logic                 upd_q, upd_d;
  logic [SETTLE_W-1:0]  cnt_q, cnt_d;
  logic [GAIN_W-1:0]    lut_rdata;
  logic [IW-1:0]        ae_next;
  logic [IW-1:0]        man_idx;
  logic                 man_hit;
  logic                 ae_hit;

  function automatic logic [IW-1:0] step_idx(input logic [IW-1:0] idx, input logic [1:0] resp);
    logic [IW-1:0] r;
    case (resp)
      AE_DARK:          r = (idx == '0) ? idx : idx - 1'b1;
      AE_BRIGHT:        r = (idx == MAX_IDX) ? idx : idx + 1'b1;
      AE_HOLD, AE_RSVD: r = idx;
      default:          r = idx;
    endcase
    return r;
  endfunction

  // Read address follows pend_d so the LUT word is ready during the APPLY cycle.
  isp_dgain_lut #(
    .SIZE (DGAIN_ARRAY_SIZE),
    .AW   (IW),
    .GW   (GAIN_W)
  ) u_lut (
    .clk   (pclk),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (pend_d),
    .rdata (lut_rdata)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    val_d   = val_q;
    upd_d   = 1'b0;
    cnt_d   = cnt_q;
    ae_next = step_idx(idx_q, ae_response);
    man_idx = (manual_index > MAX_IDX) ? MAX_IDX : manual_index;
    man_hit = manual_mode && frame_start && (man_idx != idx_q);
    ae_hit  = !manual_mode && ae_valid && (ae_next != idx_q);

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT_STATS;
        ST_WAIT_STATS: begin
          if (man_hit) begin
            pend_d  = man_idx;
            state_d = ST_APPLY;
          end else if (ae_hit) begin
            pend_d  = ae_next;
            state_d = ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (frame_start) begin
            state_d = ST_APPLY;
          end else if (!manual_mode && ae_valid) begin
            pend_d = ae_next;
            if (ae_next == idx_q) state_d = ST_WAIT_STATS;
          end
        end
        ST_APPLY: begin
          idx_d = pend_q;
          val_d = lut_rdata;
          upd_d = 1'b1;
          if (settle_frames == '0) begin
            state_d = ST_WAIT_STATS;
          end else begin
            cnt_d   = settle_frames;
            state_d = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (man_hit) begin
            pend_d  = man_idx;
            state_d = ST_APPLY;
          end else if (frame_start) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= 1) state_d = ST_WAIT_STATS;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= IW'(INIT_INDEX);
      pend_q  <= IW'(INIT_INDEX);
      val_q   <= UNITY_GAIN;
      upd_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      val_q   <= val_d;
      upd_q   <= upd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dgain_index  = idx_q;
  assign dgain_value  = val_q;
  assign dgain_update = upd_q;
  assign busy         = (state_q == ST_PENDING) || (state_q == ST_APPLY) || (state_q == ST_SETTLE);

endmodule
